rv32i_clint: RTL and testbench



---
 rtl/rv32i_clint.sv | 147 ++++++++++++++
 tb/tb_rv32i_clint.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_clint.sv
// Core-local interruptor: msip, mtime and mtimecmp behind a 1-cycle bus.
// Mirrors every mtime/mtimecmp write to the SoC with a one-cycle pulse.
module rv32i_clint #(
  parameter int unsigned CLK_FREQ_MHZ   = 100,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic        i_wr_en,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_wr_mask,
  output logic        o_ack,
  output logic [31:0] o_rd_data,
  output logic        o_software_interrupt,
  output logic        o_timer_interrupt,
  output logic        o_mtime_wr,
  output logic [63:0] o_mtime_din,
  output logic        o_mtimecmp_wr,
  output logic [63:0] o_mtimecmp_din
);

  localparam int unsigned PW =
    (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PW-1:0] P_TERM = PW'(CLK_FREQ_MHZ - 1);

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [63:0]   mtime;
  logic [63:0]   mtime_nxt;
  logic [63:0]   mtimecmp;
  logic [63:0]   mtimecmp_nxt;
  logic          msip;
  logic          tick;

  logic sel_msip;
  logic sel_cmp_lo;
  logic sel_cmp_hi;
  logic sel_mt_lo;
  logic sel_mt_hi;
  logic wr;
  logic rd;
  logic wr_mt;
  logic wr_cmp;
  logic [31:0] rd_mux;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] din,
    input logic [3:0]  m
  );
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = m[k] ? din[8*k +: 8] : old[8*k +: 8];
    end
    return r;
  endfunction

  // Exact offset compare also rejects misaligned addresses.
  assign sel_msip   = (i_addr == 5'h00);
  assign sel_cmp_lo = (i_addr == 5'h04);
  assign sel_cmp_hi = (i_addr == 5'h08);
  assign sel_mt_lo  = (i_addr == 5'h0C);
  assign sel_mt_hi  = (i_addr == 5'h10);

  assign wr     = i_stb & i_wr_en;
  assign rd     = i_stb & ~i_wr_en;
  assign wr_mt  = wr & (sel_mt_lo | sel_mt_hi);
  assign wr_cmp = wr & (sel_cmp_lo | sel_cmp_hi);
  assign tick   = (presc == P_TERM);

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_msip:   rd_mux = {31'b0, msip};
      sel_cmp_lo: rd_mux = mtimecmp[31:0];
      sel_cmp_hi: rd_mux = mtimecmp[63:32];
      sel_mt_lo:  rd_mux = mtime[31:0];
      sel_mt_hi:  rd_mux = mtime[63:32];
      default:    rd_mux = '0;
    endcase
  end

  // A bus write to mtime wins over a same-cycle tick.
  always_comb begin
    mtime_nxt = mtime;
    presc_nxt = presc + PW'(1);
    if (tick) begin
      mtime_nxt = mtime + 64'd1;
      presc_nxt = '0;
    end
    if (wr & sel_mt_lo) begin
      mtime_nxt = {mtime[63:32],
                   merge(mtime[31:0], i_wr_data, i_wr_mask)};
      presc_nxt = '0;
    end
    if (wr & sel_mt_hi) begin
      mtime_nxt = {merge(mtime[63:32], i_wr_data, i_wr_mask),
                   mtime[31:0]};
      presc_nxt = '0;
    end
  end

  always_comb begin
    mtimecmp_nxt = mtimecmp;
    if (wr & sel_cmp_lo) begin
      mtimecmp_nxt[31:0] =
        merge(mtimecmp[31:0], i_wr_data, i_wr_mask);
    end
    if (wr & sel_cmp_hi) begin
      mtimecmp_nxt[63:32] =
        merge(mtimecmp[63:32], i_wr_data, i_wr_mask);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc             <= '0;
      mtime             <= '0;
      mtimecmp          <= MTIMECMP_RESET;
      msip              <= 1'b0;
      o_ack             <= 1'b0;
      o_rd_data         <= '0;
      o_mtime_wr        <= 1'b0;
      o_mtimecmp_wr     <= 1'b0;
      o_timer_interrupt <= 1'b0;
    end else begin
      presc             <= presc_nxt;
      mtime             <= mtime_nxt;
      mtimecmp          <= mtimecmp_nxt;
      o_ack             <= i_stb;
      o_rd_data         <= rd ? rd_mux : '0;
      o_mtime_wr        <= wr_mt;
      o_mtimecmp_wr     <= wr_cmp;
      o_timer_interrupt <= (mtime >= mtimecmp);
      if (wr & sel_msip & i_wr_mask[0]) begin
        msip <= i_wr_data[0];
      end
    end
  end

  assign o_software_interrupt = msip;
  assign o_mtime_din          = mtime;
  assign o_mtimecmp_din       = mtimecmp;

endmodule

// File: tb/tb_rv32i_clint.sv
// Bench for rv32i_clint: directed plus random bus traffic,
// checked every cycle against an arithmetic time model.
module tb_rv32i_clint;

  localparam int F = 100;
  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        o_ack;
  logic [31:0] o_rd_data;
  logic        o_sirq;
  logic        o_tirq;
  logic        o_mwr;
  logic [63:0] o_mdin;
  logic        o_cwr;
  logic [63:0] o_cdin;

  rv32i_clint #(
    .CLK_FREQ_MHZ(F),
    .MTIMECMP_RESET(CMP_RST)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_stb(stb),
    .i_wr_en(we),
    .i_addr(addr),
    .i_wr_data(wdata),
    .i_wr_mask(mask),
    .o_ack(o_ack),
    .o_rd_data(o_rd_data),
    .o_software_interrupt(o_sirq),
    .o_timer_interrupt(o_tirq),
    .o_mtime_wr(o_mwr),
    .o_mtime_din(o_mdin),
    .o_mtimecmp_wr(o_cwr),
    .o_mtimecmp_din(o_cdin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mtime = m_base + (edges since anchor) / F
  logic [63:0] m_base;
  int          m_cnt;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        e_ack;
  logic [31:0] e_rd;
  logic        e_mwr;
  logic        e_cwr;
  logic        e_tirq;
  int          n_cmp;
  int          n_bad;

  function automatic logic [63:0] mt_now();
    return m_base + 64'(m_cnt / F);
  endfunction

  function automatic logic [31:0] lane(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++)
      if (m[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_model(
    input logic [4:0]  a,
    input logic [63:0] t
  );
    case (a)
      5'h00:   return {31'b0, m_msip};
      5'h04:   return m_cmp[31:0];
      5'h08:   return m_cmp[63:32];
      5'h0C:   return t[31:0];
      5'h10:   return t[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [63:0] t;
    t = mt_now();
    if (rst) begin
      m_base = '0;
      m_cnt  = 0;
      m_cmp  = CMP_RST;
      m_msip = 1'b0;
      e_ack  = 1'b0;
      e_rd   = '0;
      e_mwr  = 1'b0;
      e_cwr  = 1'b0;
      e_tirq = 1'b0;
    end else begin
      e_tirq = (t >= m_cmp);
      e_ack  = stb;
      e_rd   = (stb && !we) ? rd_model(addr, t) : 32'h0;
      e_mwr  = stb && we && (addr == 5'h0C || addr == 5'h10);
      e_cwr  = stb && we && (addr == 5'h04 || addr == 5'h08);
      m_cnt++;
      if (stb && we) begin
        case (addr)
          5'h00: if (mask[0]) m_msip = wdata[0];
          5'h04: m_cmp[31:0]  = lane(m_cmp[31:0], wdata, mask);
          5'h08: m_cmp[63:32] = lane(m_cmp[63:32], wdata, mask);
          5'h0C: begin
            m_base = {t[63:32], lane(t[31:0], wdata, mask)};
            m_cnt  = 0;
          end
          5'h10: begin
            m_base = {lane(t[63:32], wdata, mask), t[31:0]};
            m_cnt  = 0;
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    chk("ack", 64'(o_ack), 64'(e_ack));
    chk("rd_data", 64'(o_rd_data), 64'(e_rd));
    chk("mtime_wr", 64'(o_mwr), 64'(e_mwr));
    chk("mtimecmp_wr", 64'(o_cwr), 64'(e_cwr));
    chk("timer_irq", 64'(o_tirq), 64'(e_tirq));
    chk("sw_irq", 64'(o_sirq), 64'(m_msip));
    chk("mtime_din", o_mdin, mt_now());
    chk("mtimecmp_din", o_cdin, m_cmp);
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(
    input logic [4:0]  a,
    input logic [31:0] d,
    input logic [3:0]  m
  );
    stb = 1'b1; we = 1'b1; addr = a; wdata = d; mask = m;
    step();
    stb = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    stb = 1'b1; we = 1'b0; addr = a;
    step();
    stb = 1'b0;
  endtask

  logic [4:0] pick [6];

  initial begin
    n_cmp = 0; n_bad = 0;
    m_base = '0; m_cnt = 0; m_cmp = CMP_RST; m_msip = 1'b0;
    rst = 1'b1; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; mask = '0;
    pick[0] = 5'h00; pick[1] = 5'h04; pick[2] = 5'h08;
    pick[3] = 5'h0C; pick[4] = 5'h10; pick[5] = 5'h00;

    // reset with a strobe pending
    stb = 1'b1; we = 1'b1; addr = 5'h00;
    wdata = 32'h1; mask = 4'hF;
    step(); step();
    stb = 1'b0;
    step();
    chk("rst_ack", 64'(o_ack), 64'd0);
    chk("rst_cmp", o_cdin, CMP_RST);
    rst = 1'b0;

    // tick rate
    idle(1000);
    rd(5'h0C);
    chk("tick_rd", 64'(o_rd_data), 64'hA);
    chk("tick_tirq", 64'(o_tirq), 64'd0);

    // timer compare
    wr(5'h04, 32'd15, 4'hF);
    chk("cmp_lo", o_cdin, 64'hFFFF_FFFF_0000_000F);
    wr(5'h08, 32'd0, 4'hF);
    chk("cmp_pulse", 64'(o_cwr), 64'd1);
    chk("cmp_15", o_cdin, 64'd15);
    idle(700);
    chk("tirq_on", 64'(o_tirq), 64'd1);
    wr(5'h04, 32'd100, 4'hF);
    idle(1);
    chk("tirq_off", 64'(o_tirq), 64'd0);

    // software interrupt
    wr(5'h00, 32'hFFFF_FFFF, 4'hF);
    chk("msip_on", 64'(o_sirq), 64'd1);
    rd(5'h00);
    chk("msip_rd", 64'(o_rd_data), 64'd1);
    wr(5'h00, 32'h0, 4'hF);
    chk("msip_off", 64'(o_sirq), 64'd0);

    // random bus traffic
    for (int i = 0; i < 400; i++) begin
      stb   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ?
              5'($urandom_range(0, 31)) : pick[$urandom_range(0, 5)];
      wdata = $urandom;
      mask  = 4'($urandom_range(0, 15));
      step();
    end
    wr(5'h00, 32'h0, 4'h0);
    idle(3);

    // wrap and override
    wr(5'h10, 32'hFFFF_FFFF, 4'hF);
    chk("mt_pulse1", 64'(o_mwr), 64'd1);
    wr(5'h0C, 32'hFFFF_FFFF, 4'hF);
    chk("mt_pulse2", 64'(o_mwr), 64'd1);
    chk("mt_max", o_mdin, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(100);
    chk("mt_wrap", o_mdin, 64'd0);
    idle(99);
    wr(5'h0C, 32'h1234_5678, 4'hF);
    chk("mt_override", o_mdin, 64'h0000_0000_1234_5678);
    wr(5'h10, 32'h0, 4'h0);
    chk("mt_mask0_pulse", 64'(o_mwr), 64'd1);

    // reset mid-operation
    wr(5'h00, 32'h1, 4'h1);
    rst = 1'b1;
    stb = 1'b1; we = 1'b1; addr = 5'h00;
    wdata = 32'h1; mask = 4'hF;
    step();
    stb = 1'b0;
    rst = 1'b0;
    chk("mid_rst_ack", 64'(o_ack), 64'd0);
    chk("mid_rst_msip", 64'(o_sirq), 64'd0);
    chk("mid_rst_mtime", o_mdin, 64'd0);

    // bus edge cases
    rd(5'h04);
    chk("b2b_0", 64'({o_ack, o_rd_data}), 64'h1_FFFF_FFFF);
    rd(5'h08);
    chk("b2b_1", 64'({o_ack, o_rd_data}), 64'h1_FFFF_FFFF);
    rd(5'h14);
    chk("b2b_2", 64'({o_ack, o_rd_data}), 64'h1_0000_0000);
    rd(5'h02);
    chk("b2b_3", 64'({o_ack, o_rd_data}), 64'h1_0000_0000);
    wr(5'h04, 32'h0000_AB00, 4'b0010);
    chk("mask_lane", o_cdin, 64'hFFFF_FFFF_FFFF_ABFF);
    wr(5'h14, 32'hDEAD_BEEF, 4'hF);
    chk("unmapped_wr", 64'({o_ack, o_mwr, o_cwr}), 64'h4);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
